instruction_cache: RTL and testbench

INSTRUCTION_CACHE -- requirements
Module: instruction_cache

---
 rtl/instruction_cache_pkg.sv | 19 +
 rtl/icache_line_array.sv | 50 +++++
 rtl/instruction_cache.sv | 153 +++++++++++++++
 tb/tb_instruction_cache.sv | 205 ++++++++++++++++++++
 4 files changed

// File: rtl/instruction_cache_pkg.sv
// Shared definitions for the direct-mapped, read-only instruction cache.
// Holds the controller state encoding, the block-address width and the word-select helper.
package instruction_cache_pkg;

    localparam int BLOCK_ADDR_W = 28;
    localparam int LINE_W       = 128;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        FETCH  = 2'd1,
        UPDATE = 2'd2
    } icache_state_e;

    function automatic logic [31:0] select_word(input logic [LINE_W-1:0] line,
                                                input logic [1:0]        offset);
        return line[{offset, 5'd0} +: 32];
    endfunction

endpackage

// File: rtl/icache_line_array.sv
// Valid/tag/data storage for the instruction cache: one read port, one write port,
// and a flash clear that drops every valid bit in one edge.
module icache_line_array
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 8,
    parameter int INDEX_W   = $clog2(NUM_LINES),
    parameter int TAG_W     = BLOCK_ADDR_W - INDEX_W
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               flash_clear,
    input  logic [INDEX_W-1:0] rd_index,
    output logic               rd_valid,
    output logic [TAG_W-1:0]   rd_tag,
    output logic [LINE_W-1:0]  rd_data,
    input  logic               wr_en,
    input  logic [INDEX_W-1:0] wr_index,
    input  logic               wr_valid,
    input  logic [TAG_W-1:0]   wr_tag,
    input  logic [LINE_W-1:0]  wr_data
);

    logic [NUM_LINES-1:0] valid_q;
    logic [TAG_W-1:0]     tag_q  [NUM_LINES];
    logic [LINE_W-1:0]    data_q [NUM_LINES];

    // Flash clear has priority so a coincident install lands invalid.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (flash_clear) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_index] <= wr_valid;
        end
    end

    always_ff @(posedge clock) begin
        if (wr_en) begin
            tag_q[wr_index]  <= wr_tag;
            data_q[wr_index] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_index];
    assign rd_tag   = tag_q[rd_index];
    assign rd_data  = data_q[rd_index];

endmodule

// File: rtl/instruction_cache.sv
// Direct-mapped read-only instruction cache with a single-block fill from instruction memory.
// Hits are served combinationally in IDLE; misses stall through FETCH and UPDATE.
//
//   state  | meaning
//   IDLE   | serve hits; on a miss latch {tag,index} and request a fill
//   FETCH  | mem_read held with latched address until mem_busywait drops
//   UPDATE | install the captured block into the latched line, then retry
module instruction_cache
    import instruction_cache_pkg::*;
#(
    parameter int NUM_LINES = 8
) (
    input  logic                    clock,
    input  logic                    reset,
    input  logic                    cpu_read,
    input  logic [31:0]             cpu_address,
    input  logic                    invalidate,
    output logic [31:0]             instruction,
    output logic                    cpu_busywait,
    output logic                    mem_read,
    output logic [BLOCK_ADDR_W-1:0] mem_address,
    input  logic [LINE_W-1:0]       mem_readdata,
    input  logic                    mem_busywait
);

    localparam int INDEX_W = $clog2(NUM_LINES);
    localparam int TAG_W   = BLOCK_ADDR_W - INDEX_W;

    icache_state_e state_q, state_d;

    logic [BLOCK_ADDR_W-1:0] blk_addr_q;
    logic [LINE_W-1:0]       fill_q;
    logic [31:0]             instr_q;

    logic [TAG_W-1:0]   addr_tag;
    logic [INDEX_W-1:0] addr_index;
    logic [1:0]         addr_offset;
    logic               unused_addr_bits;

    logic               rd_valid;
    logic [TAG_W-1:0]   rd_tag;
    logic [LINE_W-1:0]  rd_data;
    logic               hit;
    logic [31:0]        hit_word;

    logic busy_d;
    logic mem_read_d;
    logic wr_en;
    logic latch_miss;
    logic serve_hit;
    logic capture_fill;

    assign addr_tag         = cpu_address[31:INDEX_W+4];
    assign addr_index       = cpu_address[INDEX_W+3:4];
    assign addr_offset      = cpu_address[3:2];
    assign unused_addr_bits = ^cpu_address[1:0];

    icache_line_array #(
        .NUM_LINES (NUM_LINES),
        .INDEX_W   (INDEX_W),
        .TAG_W     (TAG_W)
    ) u_line_array (
        .clock       (clock),
        .reset       (reset),
        .flash_clear (invalidate),
        .rd_index    (addr_index),
        .rd_valid    (rd_valid),
        .rd_tag      (rd_tag),
        .rd_data     (rd_data),
        .wr_en       (wr_en),
        .wr_index    (blk_addr_q[INDEX_W-1:0]),
        .wr_valid    (1'b1),
        .wr_tag      (blk_addr_q[BLOCK_ADDR_W-1:INDEX_W]),
        .wr_data     (fill_q)
    );

    assign hit      = rd_valid && (rd_tag == addr_tag);
    assign hit_word = select_word(rd_data, addr_offset);

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        busy_d       = 1'b0;
        mem_read_d   = 1'b0;
        wr_en        = 1'b0;
        latch_miss   = 1'b0;
        serve_hit    = 1'b0;
        capture_fill = 1'b0;
        case (state_q)
            IDLE: begin
                if (cpu_read) begin
                    if (hit) begin
                        serve_hit = 1'b1;
                    end else begin
                        busy_d     = 1'b1;
                        latch_miss = 1'b1;
                        state_d    = FETCH;
                    end
                end
            end
            FETCH: begin
                busy_d     = 1'b1;
                mem_read_d = 1'b1;
                if (!mem_busywait) begin
                    capture_fill = 1'b1;
                    state_d      = UPDATE;
                end
            end
            UPDATE: begin
                busy_d  = 1'b1;
                wr_en   = 1'b1;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Fill address is frozen for the whole handshake, independent of later CPU activity.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            blk_addr_q <= '0;
            instr_q    <= '0;
        end else begin
            if (latch_miss) begin
                blk_addr_q <= {addr_tag, addr_index};
            end
            if (serve_hit) begin
                instr_q <= hit_word;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (capture_fill) begin
            fill_q <= mem_readdata;
        end
    end

    assign instruction  = serve_hit ? hit_word : instr_q;
    assign cpu_busywait = busy_d & reset;
    assign mem_read     = mem_read_d;
    assign mem_address  = blk_addr_q;

endmodule

// File: tb/tb_instruction_cache.sv
// Directed bench for instruction_cache with a fixed-latency memory model and an
// expected-instruction queue popped whenever the cache releases the CPU.
module tb_instruction_cache;

    localparam int MEM_LAT   = 14;
    localparam int MISS_BUSY = MEM_LAT + 2;

    logic         clock = 1'b0;
    logic         reset;
    logic         cpu_read;
    logic [31:0]  cpu_address;
    logic         invalidate;
    logic [31:0]  instruction;
    logic         cpu_busywait;
    logic         mem_read;
    logic [27:0]  mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int checks = 0;
    int passes = 0;
    int mem_cnt;
    logic [31:0] exp_q[$];

    instruction_cache #(.NUM_LINES(8)) dut (
        .clock        (clock),
        .reset        (reset),
        .cpu_read     (cpu_read),
        .cpu_address  (cpu_address),
        .invalidate   (invalidate),
        .instruction  (instruction),
        .cpu_busywait (cpu_busywait),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 clock = ~clock;

    function automatic logic [127:0] block_of(input logic [27:0] a);
        if (a == 28'h0) return 128'h00112233_44556677_8899AABB_CCDDEEFF;
        return {4'h3, a, 4'h2, a, 4'h1, a, 4'h0, a};
    endfunction

    function automatic logic [31:0] word_of(input logic [31:0] addr);
        logic [127:0] b;
        b = block_of(addr[31:4]);
        case (addr[3:2])
            2'd0:    return b[31:0];
            2'd1:    return b[63:32];
            2'd2:    return b[95:64];
            default: return b[127:96];
        endcase
    endfunction

    always @(posedge clock or negedge reset) begin
        if (!reset)        mem_cnt <= 0;
        else if (mem_read) mem_cnt <= mem_cnt + 1;
        else               mem_cnt <= 0;
    end
    assign mem_busywait = mem_read && (mem_cnt != MEM_LAT - 1);
    assign mem_readdata = block_of(mem_address);

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic fetch(input logic [31:0] addr, input int exp_busy, input string tag);
        int  busy;
        bit  seen_rd;
        bit  addr_ok;
        bit  done;
        @(posedge clock); #1;
        cpu_read    = 1'b1;
        cpu_address = addr;
        exp_q.push_back(word_of(addr));
        busy = 0; seen_rd = 0; addr_ok = 1; done = 0;
        for (int i = 0; i < 100 && !done; i++) begin
            @(negedge clock);
            if (mem_read) begin
                seen_rd = 1;
                if (mem_address !== addr[31:4]) addr_ok = 0;
            end
            if (!cpu_busywait) begin
                done = 1;
                chk({tag, "_instr"}, 128'(instruction), 128'(exp_q.pop_front()));
            end else begin
                busy++;
            end
        end
        if (!done) begin
            chk({tag, "_timeout"}, 128'(0), 128'(1));
            exp_q.delete();
        end
        chk({tag, "_busy_cycles"}, 128'(busy), 128'(exp_busy));
        chk({tag, "_mem_read_seen"}, 128'(seen_rd), 128'(exp_busy != 0));
        if (exp_busy != 0) chk({tag, "_mem_address"}, 128'(addr_ok), 128'(1));
        @(posedge clock); #1;
        cpu_read = 1'b0;
    endtask

    task automatic start_fill(input logic [31:0] addr, input string tag);
        bit got;
        @(posedge clock); #1;
        cpu_read    = 1'b1;
        cpu_address = addr;
        got = 0;
        for (int i = 0; i < 10 && !got; i++) begin
            @(negedge clock);
            if (mem_read) got = 1;
        end
        if (!got) chk({tag, "_start_timeout"}, 128'(0), 128'(1));
        #1;
        cpu_read = 1'b0;
    endtask

    task automatic wait_last_fetch(input string tag);
        bit got;
        got = 0;
        for (int i = 0; i < 100 && !got; i++) begin
            @(negedge clock);
            if (mem_read && !mem_busywait) got = 1;
        end
        if (!got) chk({tag, "_end_timeout"}, 128'(0), 128'(1));
    endtask

    initial begin
        bit addr_stable;
        reset       = 1'b0;
        cpu_read    = 1'b1;
        cpu_address = 32'h0;
        invalidate  = 1'b0;

        repeat (3) @(negedge clock);
        chk("rst_mem_read",  128'(mem_read),     128'(0));
        chk("rst_mem_addr",  128'(mem_address),  128'(0));
        chk("rst_instr",     128'(instruction),  128'(0));
        chk("rst_busywait",  128'(cpu_busywait), 128'(0));
        #2 reset = 1'b1;
        cpu_read = 1'b0;

        fetch(32'h0000_0000, MISS_BUSY, "cold0");
        fetch(32'h0000_000C, 0, "hit0C");

        cpu_address = 32'h0000_0080;
        @(negedge clock);
        chk("hold_instr", 128'(instruction),  128'(32'h0011_2233));
        chk("hold_busy",  128'(cpu_busywait), 128'(0));

        fetch(32'h0000_0080, MISS_BUSY, "evict80");
        fetch(32'h0000_0000, MISS_BUSY, "refetch0");
        fetch(32'h0000_0004, 0, "hit04");

        @(posedge clock); #1 invalidate = 1'b1;
        @(posedge clock); #1 invalidate = 1'b0;
        fetch(32'h0000_0000, MISS_BUSY, "inval0");

        start_fill(32'h0000_0020, "chg");
        cpu_address = 32'h0000_0040;
        addr_stable = 1;
        for (int i = 0; i < 100 && mem_read; i++) begin
            if (mem_address !== 28'h000_0002) addr_stable = 0;
            @(negedge clock);
        end
        chk("chg_mem_addr_stable", 128'(addr_stable), 128'(1));
        @(negedge clock);
        chk("chg_idle_busy", 128'(cpu_busywait), 128'(0));
        fetch(32'h0000_0020, 0, "chg_hit20");

        start_fill(32'h0000_0030, "invf");
        invalidate = 1'b1;
        @(negedge clock); #1 invalidate = 1'b0;
        wait_last_fetch("invf");
        repeat (2) @(negedge clock);
        fetch(32'h0000_0030, 0, "invf_hit30");

        start_fill(32'h0000_0050, "invu");
        wait_last_fetch("invu");
        @(posedge clock); #1 invalidate = 1'b1;
        @(posedge clock); #1 invalidate = 1'b0;
        fetch(32'h0000_0050, MISS_BUSY, "invu_miss50");

        start_fill(32'h0000_0060, "rstf");
        cpu_read = 1'b1;
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1;
        chk("rstf_mem_read", 128'(mem_read),     128'(0));
        chk("rstf_busy",     128'(cpu_busywait), 128'(0));
        chk("rstf_instr",    128'(instruction),  128'(0));
        repeat (2) @(negedge clock);
        chk("rstf_mem_addr", 128'(mem_address),  128'(0));
        #2 reset = 1'b1;
        cpu_read = 1'b0;
        fetch(32'h0000_0060, MISS_BUSY, "rstf_miss60");
        fetch(32'h0000_000C, MISS_BUSY, "rstf_miss0C");

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
